aes_to_axis_if: RTL and testbench

//  Output-side glue: takes AES-CTR core result beats (valid/ready) and drives an AXIS master.

---
 rtl/aes_axis_pkg.sv | 17 +
 rtl/aes_axis_fifo.sv | 54 +++++
 rtl/aes_to_axis_if.sv | 86 ++++++++
 tb/tb_aes_to_axis_if.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_axis_pkg.sv
// Shared definitions for the AES-CTR result to AXIS output glue.
package aes_axis_pkg;

    localparam int unsigned DATA_W_DEF = 128;
    localparam int unsigned KEEP_W_DEF = DATA_W_DEF / 8;
    localparam logic [KEEP_W_DEF-1:0] KEEP_ALL = {KEEP_W_DEF{1'b1}};
    // Widest keep the contiguity helper accepts; narrower keeps are zero-extended.
    localparam int unsigned KEEP_MAX = 64;

    // True when the set bits form a single run starting at bit 0 (all-zero also passes).
    function automatic logic keep_contig(input logic [KEEP_MAX-1:0] keep);
        logic [KEEP_MAX:0] inc;
        inc = {1'b0, keep} + {{KEEP_MAX{1'b0}}, 1'b1};
        return (keep & inc[KEEP_MAX-1:0]) == '0;
    endfunction

endpackage

// File: rtl/aes_axis_fifo.sv
// Synchronous first-word-fall-through FIFO; head entry is always visible on dout.
module aes_axis_fifo #(
    parameter int unsigned WIDTH = 145,
    parameter int unsigned DEPTH = 4,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned LVL_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [LVL_W-1:0] level
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [LVL_W-1:0] level_q;
    logic             do_push;
    logic             do_pop;

    assign full    = (level_q == LVL_W'(DEPTH));
    assign empty   = (level_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr_q];
    assign level   = level_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr_q] <= din;
                wr_ptr_q      <= wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            unique case ({do_push, do_pop})
                2'b10:   level_q <= level_q + LVL_W'(1);
                2'b01:   level_q <= level_q - LVL_W'(1);
                default: level_q <= level_q;
            endcase
        end
    end

endmodule

// File: rtl/aes_to_axis_if.sv
// AES-CTR result beats to AXIS master, buffered through a small FWFT FIFO,
// with a completed-frame counter and a sticky malformed-keep flag.
module aes_to_axis_if
    import aes_axis_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned KEEP_W = DATA_W / 8,
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned CNT_W  = 32,
    localparam int unsigned LVL_W = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              out_valid,
    output logic              out_ready,
    input  logic [DATA_W-1:0] out_data,
    input  logic [KEEP_W-1:0] out_keep,
    input  logic              out_last,
    output logic [DATA_W-1:0] m_tdata,
    output logic [KEEP_W-1:0] m_tkeep,
    output logic              m_tlast,
    output logic              m_tvalid,
    input  logic              m_tready,
    output logic [LVL_W-1:0]  level,
    output logic [CNT_W-1:0]  frames,
    output logic              keep_err
);

    localparam int unsigned ENTRY_W = DATA_W + KEEP_W + 1;
    localparam logic [KEEP_W-1:0] KEEP_ONES = {KEEP_W{1'b1}};

    logic               push;
    logic               pop;
    logic               full;
    logic               empty;
    logic [ENTRY_W-1:0] head;
    logic [CNT_W-1:0]   frames_q;
    logic               keep_err_q;
    logic               keep_bad;

    // Both handshake sides depend only on registered FIFO occupancy.
    assign out_ready = !full;
    assign m_tvalid  = !empty;
    assign push      = out_valid && out_ready;
    assign pop       = m_tvalid && m_tready;
    assign {m_tdata, m_tkeep, m_tlast} = head;
    assign frames    = frames_q;
    assign keep_err  = keep_err_q;

    aes_axis_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   ({out_data, out_keep, out_last}),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .level (level)
    );

    always_comb begin
        keep_bad = (out_keep == '0)
                || (!out_last && (out_keep != KEEP_ONES))
                || !keep_contig(KEEP_MAX'(out_keep));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            frames_q   <= '0;
            keep_err_q <= 1'b0;
        end else begin
            if (pop && m_tlast) begin
                frames_q <= frames_q + CNT_W'(1);
            end
            // Flag only; the offending beat is still forwarded.
            if (push && keep_bad) begin
                keep_err_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_aes_to_axis_if.sv
// Bench for aes_to_axis_if: queue-based reference model, keep-rule table and corner sequences.
module tb_aes_to_axis_if;

    localparam int DEPTH = 4;

    typedef struct {
        logic [127:0] data;
        logic [15:0]  keep;
        bit           last;
    } beat_t;

    typedef struct {
        bit          rst_first;
        logic [15:0] keep;
        bit          last;
        bit          exp_err;
    } keep_vec_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         out_valid = 1'b0;
    logic         out_ready;
    logic [127:0] out_data = '0;
    logic [15:0]  out_keep = '0;
    logic         out_last = 1'b0;
    logic [127:0] m_tdata;
    logic [15:0]  m_tkeep;
    logic         m_tlast;
    logic         m_tvalid;
    logic         m_tready = 1'b0;
    logic [2:0]   level;
    logic [31:0]  frames;
    logic         keep_err;

    logic         b_valid = 1'b0;
    logic         b_ready;
    logic [127:0] b_data = '0;
    logic [15:0]  b_keep = 16'hFFFF;
    logic         b_last = 1'b1;
    logic [127:0] b_tdata;
    logic [15:0]  b_tkeep;
    logic         b_tlast;
    logic         b_tvalid;
    logic         b_tready = 1'b1;
    logic [2:0]   b_level;
    logic [3:0]   b_frames;
    logic         b_keep_err;

    int n_cmp = 0;
    int n_err = 0;

    beat_t        mq[$];
    logic [127:0] popped[$];
    logic [31:0]  m_frames = '0;
    bit           m_err = 1'b0;
    bit           last_push;

    always #5 clk = ~clk;

    aes_to_axis_if dut (
        .clk(clk), .rst(rst), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_keep(out_keep), .out_last(out_last),
        .m_tdata(m_tdata), .m_tkeep(m_tkeep), .m_tlast(m_tlast), .m_tvalid(m_tvalid),
        .m_tready(m_tready), .level(level), .frames(frames), .keep_err(keep_err)
    );

    aes_to_axis_if #(.CNT_W(4)) dut_b (
        .clk(clk), .rst(rst), .out_valid(b_valid), .out_ready(b_ready),
        .out_data(b_data), .out_keep(b_keep), .out_last(b_last),
        .m_tdata(b_tdata), .m_tkeep(b_tkeep), .m_tlast(b_tlast), .m_tvalid(b_tvalid),
        .m_tready(b_tready), .level(b_level), .frames(b_frames), .keep_err(b_keep_err)
    );

    function automatic void chk(string name, logic [127:0] act, logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endfunction

    // Keep rules stated directly: non-empty, full unless last, one run of ones from bit 0.
    function automatic bit bad_keep(logic [15:0] k, bit l);
        bit seen_zero;
        seen_zero = 1'b0;
        if (k == 16'h0) return 1'b1;
        if (!l && k != 16'hFFFF) return 1'b1;
        for (int i = 0; i < 16; i++) begin
            if (!k[i]) seen_zero = 1'b1;
            else if (seen_zero) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic compare_all();
        chk("level", level, mq.size());
        chk("out_ready", out_ready, mq.size() != DEPTH);
        chk("m_tvalid", m_tvalid, mq.size() != 0);
        chk("frames", frames, m_frames);
        chk("keep_err", keep_err, m_err);
        if (mq.size() != 0) begin
            chk("m_tdata", m_tdata, mq[0].data);
            chk("m_tkeep", m_tkeep, mq[0].keep);
            chk("m_tlast", m_tlast, mq[0].last);
        end
    endtask

    task automatic tick();
        bit    pu;
        bit    po;
        beat_t b;
        pu = out_valid && (mq.size() < DEPTH);
        po = (mq.size() > 0) && m_tready;
        @(posedge clk);
        #1;
        if (rst) begin
            mq.delete();
            m_frames = '0;
            m_err    = 1'b0;
            pu       = 1'b0;
        end else begin
            if (po) begin
                popped.push_back(mq[0].data);
                if (mq[0].last) m_frames++;
                void'(mq.pop_front());
            end
            if (pu) begin
                b.data = out_data;
                b.keep = out_keep;
                b.last = out_last;
                mq.push_back(b);
                if (bad_keep(out_keep, out_last)) m_err = 1'b1;
            end
        end
        last_push = pu;
        compare_all();
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        out_valid = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic drain();
        out_valid = 1'b0;
        m_tready  = 1'b1;
        for (int c = 0; c < 20 && mq.size() != 0; c++) tick();
        chk("drain_empty", m_tvalid, 1'b0);
    endtask

    keep_vec_t kv[10];
    int        idx;
    int        pushes;
    logic [127:0] base;

    initial begin
        kv[0] = '{1'b1, 16'h00FF, 1'b1, 1'b0};
        kv[1] = '{1'b0, 16'h0F0F, 1'b1, 1'b1};
        kv[2] = '{1'b0, 16'h7FFF, 1'b0, 1'b1};
        kv[3] = '{1'b1, 16'h0000, 1'b1, 1'b1};
        kv[4] = '{1'b1, 16'hFFFF, 1'b0, 1'b0};
        kv[5] = '{1'b1, 16'h7FFF, 1'b0, 1'b1};
        kv[6] = '{1'b1, 16'h8000, 1'b1, 1'b1};
        kv[7] = '{1'b1, 16'h0001, 1'b1, 1'b0};
        kv[8] = '{1'b1, 16'hFFFF, 1'b1, 1'b0};
        kv[9] = '{1'b1, 16'h00FE, 1'b1, 1'b1};

        do_reset();
        do_reset();

        // Single beat: one-cycle latency, no bypass.
        out_valid = 1'b1;
        out_data  = 128'h00112233_44556677_8899AABB_CCDDEEFF;
        out_keep  = 16'hFFFF;
        out_last  = 1'b1;
        m_tready  = 1'b1;
        chk("t1_no_bypass", m_tvalid, 1'b0);
        tick();
        out_valid = 1'b0;
        chk("t1_valid", m_tvalid, 1'b1);
        chk("t1_data", m_tdata, 128'h00112233_44556677_8899AABB_CCDDEEFF);
        tick();
        chk("t1_frames", frames, 32'd1);
        chk("t1_level", level, 3'd0);

        // Fill while stalled, fifth beat held, then release in order.
        do_reset();
        base     = 128'hA000;
        m_tready = 1'b0;
        idx      = 0;
        popped.delete();
        for (int c = 0; c < 40 && popped.size() < 5; c++) begin
            out_valid = (idx < 5);
            out_data  = base + 128'(idx);
            out_keep  = 16'hFFFF;
            out_last  = (idx == 4);
            if (c == 6) m_tready = 1'b1;
            tick();
            if (last_push) idx++;
            if (c == 3) begin
                chk("t2_full_level", level, 3'd4);
                chk("t2_full_ready", out_ready, 1'b0);
            end
            if (c >= 3 && c <= 5) chk("t2_head_stable", m_tdata, base);
            if (c == 5) chk("t2_fifth_held", 128'(idx), 128'd4);
        end
        chk("t2_count", popped.size(), 5);
        for (int i = 0; i < 5 && i < popped.size(); i++) chk("t2_order", popped[i], base + 128'(i));
        drain();

        // Steady push&pop at level 2.
        do_reset();
        base      = 128'hB000;
        m_tready  = 1'b0;
        out_valid = 1'b1;
        out_keep  = 16'hFFFF;
        out_last  = 1'b0;
        for (int i = 0; i < 2; i++) begin
            out_data = base + 128'(i);
            tick();
        end
        popped.delete();
        m_tready = 1'b1;
        for (int i = 2; i < 12; i++) begin
            out_data = base + 128'(i);
            tick();
            chk("t3_level", level, 3'd2);
        end
        chk("t3_count", popped.size(), 10);
        for (int i = 0; i < 10 && i < popped.size(); i++) chk("t3_order", popped[i], base + 128'(i));
        drain();

        // Keep rules: table of single beats, sticky unless the record resets first.
        for (int i = 0; i < 10; i++) begin
            if (kv[i].rst_first) do_reset();
            m_tready  = 1'b1;
            out_valid = 1'b1;
            out_data  = 128'(i) + 128'hC000;
            out_keep  = kv[i].keep;
            out_last  = kv[i].last;
            tick();
            out_valid = 1'b0;
            chk("t4_fwd_keep", m_tkeep, kv[i].keep);
            tick();
            chk("t4_keep_err", keep_err, kv[i].exp_err);
        end

        // Randomized traffic against the queue model.
        do_reset();
        for (int c = 0; c < 400; c++) begin
            out_valid = ($urandom_range(0, 3) != 0);
            m_tready  = ($urandom_range(0, 2) != 0);
            out_data  = {$urandom(), $urandom(), $urandom(), $urandom()};
            out_last  = ($urandom_range(0, 3) == 0);
            out_keep  = out_last ? (16'hFFFF >> $urandom_range(0, 15)) : 16'hFFFF;
            if ($urandom_range(0, 19) == 0) out_keep = 16'($urandom());
            tick();
        end
        drain();

        // Reset mid-frame with occupancy 3.
        m_tready  = 1'b0;
        out_valid = 1'b1;
        out_last  = 1'b0;
        out_keep  = 16'hFFFF;
        for (int c = 0; c < 10 && mq.size() < 3; c++) begin
            out_data = 128'hD000 + 128'(c);
            tick();
        end
        out_valid = 1'b0;
        chk("t5_level3", level, 3'd3);
        do_reset();
        chk("t5_valid", m_tvalid, 1'b0);
        chk("t5_level", level, 3'd0);
        chk("t5_frames", frames, 32'd0);
        chk("t5_ready", out_ready, 1'b1);

        // Narrow counter wraps: 17 frames on a 4-bit counter.
        do_reset();
        pushes = 0;
        for (int c = 0; c < 200 && (pushes < 17 || b_tvalid); c++) begin
            bit bpu;
            b_valid = (pushes < 17);
            b_data  = 128'(pushes);
            bpu     = b_valid && b_ready;
            tick();
            if (bpu) pushes++;
        end
        b_valid = 1'b0;
        chk("t6_pushes", 128'(pushes), 128'd17);
        chk("t6_drained", b_tvalid, 1'b0);
        chk("t6_frames", b_frames, 4'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
